// File: rtl/address_gen_multi.sv
// address_gen_multi
//   Multi-lane read-address generator for the classifier's weight/pixel ROMs.
//   Every group presents LANES consecutive word addresses (lane k = ptr+k).
//   Each consumed group advances the pointer by STRIDE and the remaining word
//   count by LANES. The final, possibly partial, group is flagged with 'last'.
//   In the default build a run ends with a one-cycle 'done' pulse.
//
//   Optional feature, selected by the macro ADDR_GEN_WRAP_EN:
//     When it is defined, the run does not finish after its final group. It
//     reloads the base address and length latched at start, bumps frame_cnt
//     and keeps running until abort, start or reset. When it is undefined, the
//     wrap logic and the latched copies are not built and frame_cnt reads 0.
module address_gen_multi #(
  parameter int ADDR_W = 16,
  parameter int LANES  = 2,
  parameter int STRIDE = 2,
  parameter int FCNT_W = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       length,
  input  logic                    address_enable,
  output logic [LANES*ADDR_W-1:0] addr_out,
  output logic [LANES-1:0]        lane_valid,
  output logic                    busy,
  output logic                    last,
  output logic                    done,
  output logic [FCNT_W-1:0]       frame_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] LANES_W  = ADDR_W'(LANES);
  localparam logic [ADDR_W-1:0] STRIDE_W = ADDR_W'(STRIDE);

  logic [1:0]        state_q;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [ADDR_W-1:0] rem_q;
  logic [ADDR_W-1:0] rem_nxt;

  logic is_run;
  logic do_load;
  logic end_of_pass;

`ifdef ADDR_GEN_WRAP_EN
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic [FCNT_W-1:0] fcnt_nxt;
`endif

  // In RUN an abort outranks a start; in IDLE and DONE abort is meaningless,
  // so a start there always loads. rem counts the current group, so the
  // current group is the final one once no more than LANES words are left.
  assign is_run      = (state_q == ST_RUN);
  assign do_load     = start && !(is_run && abort);
  assign end_of_pass = (rem_q <= LANES_W);

  // Next-state decode: a load (fresh run or restart) overrides everything
  // else; otherwise only RUN reacts to address_enable and DONE lasts a cycle.
  always_comb begin
    state_nxt = state_q;
    ptr_nxt   = ptr_q;
    rem_nxt   = rem_q;
`ifdef ADDR_GEN_WRAP_EN
    fcnt_nxt  = fcnt_q;
`endif
    if (do_load) begin
      ptr_nxt   = base_addr;
      rem_nxt   = length;
      state_nxt = (length != '0) ? ST_RUN : ST_DONE;
`ifdef ADDR_GEN_WRAP_EN
      fcnt_nxt  = '0;
`endif
    end else begin
      case (state_q)
        ST_RUN: begin
          if (abort) begin
            state_nxt = ST_IDLE;
          end else if (address_enable) begin
            if (!end_of_pass) begin
              ptr_nxt = ptr_q + STRIDE_W;
              rem_nxt = rem_q - LANES_W;
            end else begin
`ifdef ADDR_GEN_WRAP_EN
              ptr_nxt  = base_q;
              rem_nxt  = len_q;
              fcnt_nxt = fcnt_q + FCNT_W'(1);
`else
              state_nxt = ST_DONE;
`endif
            end
          end
        end
        ST_DONE: begin
          state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Core registers: state, group pointer and words remaining.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_nxt;
      ptr_q   <= ptr_nxt;
      rem_q   <= rem_nxt;
    end
  end

`ifdef ADDR_GEN_WRAP_EN
  // Keep the run window so every pass can restart from the same base/length.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base_q <= '0;
      len_q  <= '0;
    end else if (do_load) begin
      base_q <= base_addr;
      len_q  <= length;
    end
  end

  // Count completed passes; cleared by every start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_nxt;
    end
  end

  assign frame_cnt = fcnt_q;
`else
  assign frame_cnt = '0;
`endif

  // Lane decode straight from the registers, so nothing on the inputs
  // reaches the outputs combinationally. Lanes wrap modulo 2**ADDR_W.
  always_comb begin
    addr_out   = '0;
    lane_valid = '0;
    for (int k = 0; k < LANES; k++) begin
      addr_out[k*ADDR_W +: ADDR_W] = ptr_q + ADDR_W'(k);
      lane_valid[k]                = is_run && (rem_q > ADDR_W'(k));
    end
  end

  // Status flags decoded from the state register and the remaining count.
  assign busy = is_run;
  assign last = is_run && end_of_pass;
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_address_gen_multi.sv
// tb_address_gen_multi
//   Self-checking bench for address_gen_multi (ADDR_W=16, LANES=2, STRIDE=2).
//   Directed vectors with fixed expectations, hand-written corner sequences
//   and a random phase checked against a group-index reference model.
//   Honours ADDR_GEN_WRAP_EN when it is defined for the whole build.
module tb_address_gen_multi;

  localparam int ADDR_W = 16;
  localparam int LANES  = 2;
  localparam int STRIDE = 2;
  localparam int FCNT_W = 8;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_DONE = 2;

  typedef struct packed {
    logic [LANES*ADDR_W-1:0] addr;
    logic [LANES-1:0]        lv;
    logic                    busy;
    logic                    last;
    logic                    done;
    logic [FCNT_W-1:0]       fcnt;
  } out_t;

  typedef struct {
    logic              s;
    logic              a;
    logic              e;
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] l;
    out_t              exp;
  } vec_t;

  logic                    clock;
  logic                    reset_n;
  logic                    start;
  logic                    abort;
  logic [ADDR_W-1:0]       base_addr;
  logic [ADDR_W-1:0]       length;
  logic                    address_enable;
  logic [LANES*ADDR_W-1:0] addr_out;
  logic [LANES-1:0]        lane_valid;
  logic                    busy;
  logic                    last;
  logic                    done;
  logic [FCNT_W-1:0]       frame_cnt;

  int errors;
  int checks;

  // Reference model: a run is described by its base, its length and the
  // index of the group being presented; everything else is derived from it.
  int m_phase;
  int m_base;
  int m_len;
  int m_grp;
  int m_frames;

  vec_t vecs[16];

  address_gen_multi #(
    .ADDR_W(ADDR_W),
    .LANES (LANES),
    .STRIDE(STRIDE),
    .FCNT_W(FCNT_W)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .base_addr     (base_addr),
    .length        (length),
    .address_enable(address_enable),
    .addr_out      (addr_out),
    .lane_valid    (lane_valid),
    .busy          (busy),
    .last          (last),
    .done          (done),
    .frame_cnt     (frame_cnt)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Guard against a stuck simulation.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int groups(input int len);
    return (len + LANES - 1) / LANES;
  endfunction

  function automatic out_t mkOut(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                                 input logic [1:0] lv, input logic bz, input logic ls,
                                 input logic dn, input logic [FCNT_W-1:0] fc);
    out_t o;
    o.addr = {a1, a0};
    o.lv   = lv;
    o.busy = bz;
    o.last = ls;
    o.done = dn;
    o.fcnt = fc;
    return o;
  endfunction

  function automatic vec_t mkVec(input logic s, input logic a, input logic e,
                                 input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l,
                                 input out_t exp);
    vec_t v;
    v.s   = s;
    v.a   = a;
    v.e   = e;
    v.b   = b;
    v.l   = l;
    v.exp = exp;
    return v;
  endfunction

  function automatic out_t modelOut();
    out_t o;
    int   rem;
    o      = '0;
    rem    = m_len - m_grp * LANES;
    o.busy = (m_phase == PH_RUN);
    o.done = (m_phase == PH_DONE);
    o.last = o.busy && (m_grp == groups(m_len) - 1);
    o.fcnt = FCNT_W'(m_frames);
    for (int k = 0; k < LANES; k++) begin
      o.addr[k*ADDR_W +: ADDR_W] = ADDR_W'(m_base + m_grp * STRIDE + k);
      o.lv[k] = o.busy && (k < rem);
    end
    return o;
  endfunction

  task automatic modelReset();
    m_phase  = PH_IDLE;
    m_base   = 0;
    m_len    = 0;
    m_grp    = 0;
    m_frames = 0;
  endtask

  task automatic modelStep(input logic s, input logic a, input logic e,
                           input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
    if (m_phase == PH_RUN && a) begin
      m_phase = PH_IDLE;
    end else if (s) begin
      m_base   = int'(b);
      m_len    = int'(l);
      m_grp    = 0;
      m_frames = 0;
      m_phase  = (l != 0) ? PH_RUN : PH_DONE;
    end else if (m_phase == PH_RUN) begin
      if (e) begin
        if (m_grp + 1 < groups(m_len)) begin
          m_grp = m_grp + 1;
        end else begin
`ifdef ADDR_GEN_WRAP_EN
          m_grp    = 0;
          m_frames = m_frames + 1;
`else
          m_phase = PH_DONE;
`endif
        end
      end
    end else if (m_phase == PH_DONE) begin
      m_phase = PH_IDLE;
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model.
  task automatic applyStimulus(input logic s, input logic a, input logic e,
                               input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
    start          = s;
    abort          = a;
    address_enable = e;
    base_addr      = b;
    length         = l;
    @(posedge clock);
    modelStep(s, a, e, b, l);
    #1;
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    out_t act;
    act.addr = addr_out;
    act.lv   = lane_valid;
    act.busy = busy;
    act.last = last;
    act.done = done;
    act.fcnt = frame_cnt;
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got addr=%h lv=%b busy=%b last=%b done=%b fcnt=%0d, required addr=%h lv=%b busy=%b last=%b done=%b fcnt=%0d",
               name, act.addr, act.lv, act.busy, act.last, act.done, act.fcnt,
               exp.addr, exp.lv, exp.busy, exp.last, exp.done, exp.fcnt);
    end
  endtask

  initial begin
    logic              rs;
    logic              ra;
    logic              re;
    logic [ADDR_W-1:0] rb;
    logic [ADDR_W-1:0] rl;
    out_t              exp;

    errors = 0;
    checks = 0;
    modelReset();

    // Directed vectors: full run, partial last group, empty run, restart, abort.
    vecs[0]  = mkVec(1, 0, 0, 16'd100, 16'd6, mkOut(16'd100, 16'd101, 2'b11, 1, 0, 0, 0));
    vecs[1]  = mkVec(0, 0, 1, 16'd0,   16'd0, mkOut(16'd102, 16'd103, 2'b11, 1, 0, 0, 0));
    vecs[2]  = mkVec(0, 0, 0, 16'd0,   16'd0, mkOut(16'd102, 16'd103, 2'b11, 1, 0, 0, 0));
    vecs[3]  = mkVec(0, 0, 1, 16'd0,   16'd0, mkOut(16'd104, 16'd105, 2'b11, 1, 1, 0, 0));
    vecs[4]  = mkVec(0, 0, 1, 16'd0,   16'd0, mkOut(16'd104, 16'd105, 2'b00, 0, 0, 1, 0));
    vecs[5]  = mkVec(0, 0, 0, 16'd0,   16'd0, mkOut(16'd104, 16'd105, 2'b00, 0, 0, 0, 0));
    vecs[6]  = mkVec(1, 0, 0, 16'd100, 16'd5, mkOut(16'd100, 16'd101, 2'b11, 1, 0, 0, 0));
    vecs[7]  = mkVec(0, 0, 1, 16'd0,   16'd0, mkOut(16'd102, 16'd103, 2'b11, 1, 0, 0, 0));
    vecs[8]  = mkVec(0, 0, 1, 16'd0,   16'd0, mkOut(16'd104, 16'd105, 2'b01, 1, 1, 0, 0));
    vecs[9]  = mkVec(0, 0, 1, 16'd0,   16'd0, mkOut(16'd104, 16'd105, 2'b00, 0, 0, 1, 0));
    vecs[10] = mkVec(1, 0, 0, 16'd200, 16'd0, mkOut(16'd200, 16'd201, 2'b00, 0, 0, 1, 0));
    vecs[11] = mkVec(0, 0, 1, 16'd0,   16'd0, mkOut(16'd200, 16'd201, 2'b00, 0, 0, 0, 0));
    vecs[12] = mkVec(1, 0, 0, 16'd300, 16'd2, mkOut(16'd300, 16'd301, 2'b11, 1, 1, 0, 0));
    vecs[13] = mkVec(1, 0, 1, 16'd400, 16'd4, mkOut(16'd400, 16'd401, 2'b11, 1, 0, 0, 0));
    vecs[14] = mkVec(0, 1, 1, 16'd0,   16'd0, mkOut(16'd400, 16'd401, 2'b00, 0, 0, 0, 0));
    vecs[15] = mkVec(0, 1, 1, 16'd0,   16'd0, mkOut(16'd400, 16'd401, 2'b00, 0, 0, 0, 0));

    start          = 1'b0;
    abort          = 1'b0;
    address_enable = 1'b0;
    base_addr      = '0;
    length         = '0;
    reset_n        = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_state", mkOut(16'd0, 16'd1, 2'b00, 0, 0, 0, 0));
    reset_n = 1'b1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].s, vecs[i].a, vecs[i].e, vecs[i].b, vecs[i].l);
`ifdef ADDR_GEN_WRAP_EN
      exp = modelOut();
`else
      exp = vecs[i].exp;
`endif
      checkOutput($sformatf("table[%0d]", i), exp);
    end

    $display("[TB] address wrap with enable gaps, abort, restart");
    applyStimulus(1, 0, 0, 16'hFFFE, 16'd4);
    checkOutput("wrap_first", mkOut(16'hFFFE, 16'hFFFF, 2'b11, 1, 0, 0, 0));
    for (int g = 0; g < 3; g++) begin
      applyStimulus(0, 0, 0, 16'h1234, 16'd9);
      checkOutput($sformatf("wrap_gap[%0d]", g), mkOut(16'hFFFE, 16'hFFFF, 2'b11, 1, 0, 0, 0));
    end
    applyStimulus(0, 0, 1, 16'd0, 16'd0);
    checkOutput("wrap_second", mkOut(16'h0000, 16'h0001, 2'b11, 1, 1, 0, 0));
    applyStimulus(0, 1, 0, 16'd0, 16'd0);
    checkOutput("abort_idle", mkOut(16'h0000, 16'h0001, 2'b00, 0, 0, 0, 0));
    applyStimulus(0, 0, 0, 16'd0, 16'd0);
    checkOutput("abort_no_done", modelOut());
    applyStimulus(1, 0, 1, 16'd500, 16'd8);
    applyStimulus(1, 0, 1, 16'd600, 16'd8);
    checkOutput("restart_wins", mkOut(16'd600, 16'd601, 2'b11, 1, 0, 0, 0));

    $display("[TB] asynchronous reset mid-run");
    applyStimulus(1, 0, 0, 16'd50, 16'd20);
    applyStimulus(0, 0, 1, 16'd0, 16'd0);
    checkOutput("pre_reset", mkOut(16'd52, 16'd53, 2'b11, 1, 0, 0, 0));
    #3;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset", mkOut(16'd0, 16'd1, 2'b00, 0, 0, 0, 0));
    @(posedge clock);
    #1;
    checkOutput("reset_held", modelOut());
    reset_n = 1'b1;

    $display("[TB] end-of-pass behaviour");
    applyStimulus(1, 0, 0, 16'd0, 16'd4);
    checkOutput("pass_g0", mkOut(16'd0, 16'd1, 2'b11, 1, 0, 0, 0));
    applyStimulus(0, 0, 1, 16'd0, 16'd0);
    checkOutput("pass_g1", mkOut(16'd2, 16'd3, 2'b11, 1, 1, 0, 0));
`ifdef ADDR_GEN_WRAP_EN
    applyStimulus(0, 0, 1, 16'd0, 16'd0);
    checkOutput("frame1_g0", mkOut(16'd0, 16'd1, 2'b11, 1, 0, 0, 8'd1));
    applyStimulus(0, 0, 1, 16'd0, 16'd0);
    checkOutput("frame1_g1", mkOut(16'd2, 16'd3, 2'b11, 1, 1, 0, 8'd1));
    applyStimulus(0, 0, 1, 16'd0, 16'd0);
    checkOutput("frame2_g0", mkOut(16'd0, 16'd1, 2'b11, 1, 0, 0, 8'd2));
    applyStimulus(0, 1, 0, 16'd0, 16'd0);
    checkOutput("frame_abort", mkOut(16'd0, 16'd1, 2'b00, 0, 0, 0, 8'd2));
`else
    applyStimulus(0, 0, 1, 16'd0, 16'd0);
    checkOutput("pass_done", mkOut(16'd2, 16'd3, 2'b00, 0, 0, 1, 0));
    applyStimulus(0, 0, 1, 16'd0, 16'd0);
    checkOutput("pass_idle", mkOut(16'd2, 16'd3, 2'b00, 0, 0, 0, 0));
`endif

    $display("[TB] randomized traffic against model");
    for (int i = 0; i < 400; i++) begin
      rs = ($urandom_range(0, 15) == 0);
      ra = ($urandom_range(0, 31) == 0);
      re = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin
        rb = 16'hFFFC + 16'($urandom_range(0, 3));
      end else begin
        rb = 16'($urandom);
      end
      if ($urandom_range(0, 4) == 0) begin
        rl = '0;
      end else begin
        rl = 16'($urandom_range(1, 9));
      end
      applyStimulus(rs, ra, re, rb, rl);
      checkOutput($sformatf("random[%0d]", i), modelOut());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
